// File: rtl/match_controller_if.sv
// Signal bundle between the match controller, the button debouncers, the physics engine
// and the score renderer. phys_valid is a 1-cycle strobe the cycle after each phys_en.
interface match_controller_if;
    logic       start_btn;
    logic       pause_btn;
    logic [3:0] p1_btn_in;
    logic [3:0] p2_btn_in;
    logic       phys_game_over;
    logic [1:0] phys_winner;
    logic       phys_valid;
    logic       frame_tick;
    logic       phys_en;
    logic       phys_rst_n;
    logic [3:0] p1_btn_out;
    logic [3:0] p2_btn_out;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] match_winner;
    logic [2:0] state;

    modport master (
        input  start_btn, pause_btn, p1_btn_in, p2_btn_in,
               phys_game_over, phys_winner, phys_valid,
        output frame_tick, phys_en, phys_rst_n, p1_btn_out, p2_btn_out,
               p1_score, p2_score, match_winner, state
    );

    modport slave (
        output start_btn, pause_btn, p1_btn_in, p2_btn_in,
               phys_game_over, phys_winner, phys_valid,
        input  frame_tick, phys_en, phys_rst_n, p1_btn_out, p2_btn_out,
               p1_score, p2_score, match_winner, state
    );
endinterface

// File: rtl/match_controller.sv
// Match sequencer: frame tick divider, engine gating, scoring and the
// serve / play / pause / point / over state machine.
module match_controller #(
    parameter int CLK_HZ       = 25_000_000,
    parameter int FRAME_HZ     = 60,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 90,
    parameter int POINT_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    match_controller_if.master bus
);
    localparam int DIV  = CLK_HZ / FRAME_HZ;
    localparam int DW   = $clog2(DIV);
    localparam int FMAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_POINT = 3'd4,
        S_OVER  = 3'd5
    } state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [DW-1:0] r_div_cnt;
    logic [FW-1:0] r_frm_cnt;
    logic          r_armed;
    logic [3:0]    r_p1_score;
    logic [3:0]    r_p2_score;
    logic [1:0]    r_match_winner;
    logic          r_phys_rst_n;

    logic          w_frame_tick;
    logic          w_point_evt;
    logic          w_p1_wins;
    logic [3:0]    w_p1_new;
    logic [3:0]    w_p2_new;
    logic          w_win_hit;
    logic          w_serve_done;
    logic          w_point_done;
    logic          w_clear_scores;

    assign w_frame_tick = (r_div_cnt == DW'(DIV - 1));
    assign w_p1_wins    = (bus.phys_winner == 2'd1);
    // Only the first game_over report after an un-ended frame counts; the engine
    // keeps game_over asserted until its next enabled frame.
    assign w_point_evt  = (r_state == S_PLAY) && bus.phys_valid && bus.phys_game_over &&
                          r_armed && (bus.phys_winner == 2'd1 || bus.phys_winner == 2'd2);
    assign w_p1_new     = r_p1_score + 4'd1;
    assign w_p2_new     = r_p2_score + 4'd1;
    assign w_win_hit    = w_p1_wins ? (w_p1_new == 4'(WIN_SCORE)) : (w_p2_new == 4'(WIN_SCORE));
    assign w_serve_done = w_frame_tick && (r_frm_cnt == FW'(SERVE_FRAMES - 1));
    assign w_point_done = w_frame_tick && (r_frm_cnt == FW'(POINT_FRAMES - 1));

    always_comb begin
        w_state_next   = r_state;
        w_clear_scores = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_btn) begin
                    w_state_next   = S_SERVE;
                    w_clear_scores = 1'b1;
                end
            end
            S_SERVE: if (w_serve_done) w_state_next = S_PLAY;
            S_PLAY: begin
                if (w_point_evt)        w_state_next = w_win_hit ? S_OVER : S_POINT;
                else if (bus.pause_btn) w_state_next = S_PAUSE;
            end
            S_PAUSE: if (bus.pause_btn) w_state_next = S_PLAY;
            S_POINT: if (w_point_done) w_state_next = S_SERVE;
            S_OVER:  if (bus.start_btn) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_phys_rst_n <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_phys_rst_n <= (w_state_next != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_frame_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frm_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_frm_cnt <= '0;
        end else if (w_frame_tick && (r_state == S_SERVE || r_state == S_POINT)) begin
            r_frm_cnt <= r_frm_cnt + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b1;
        end else if (w_point_evt) begin
            r_armed <= 1'b0;
        end else if (bus.phys_valid && !bus.phys_game_over) begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear_scores) begin
            r_p1_score     <= 4'd0;
            r_p2_score     <= 4'd0;
            r_match_winner <= 2'd0;
        end else if (w_point_evt) begin
            if (w_p1_wins) r_p1_score <= w_p1_new;
            else           r_p2_score <= w_p2_new;
            if (w_win_hit) r_match_winner <= bus.phys_winner;
        end
    end

    assign bus.frame_tick   = w_frame_tick;
    assign bus.phys_en      = w_frame_tick && (r_state == S_PLAY);
    assign bus.phys_rst_n   = r_phys_rst_n;
    assign bus.p1_btn_out   = (r_state == S_PLAY) ? bus.p1_btn_in : 4'b0;
    assign bus.p2_btn_out   = (r_state == S_PLAY) ? bus.p2_btn_in : 4'b0;
    assign bus.p1_score     = r_p1_score;
    assign bus.p2_score     = r_p2_score;
    assign bus.match_winner = r_match_winner;
    assign bus.state        = r_state;
endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with DIV=10, SERVE_FRAMES=3, POINT_FRAMES=2, WIN_SCORE=2.
module tb_match_controller;
    localparam int A_START = 0;
    localparam int A_PAUSE = 1;
    localparam int A_TICKS = 2;
    localparam int A_POINT = 3;

    typedef struct {
        int         act;
        int         arg;
        logic [2:0] st;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [1:0] win;
        logic       rstn;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    match_controller_if bus();

    match_controller #(
        .CLK_HZ(600), .FRAME_HZ(60), .WIN_SCORE(2), .SERVE_FRAMES(3), .POINT_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    vec_t vecs[0:19];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic wait_tick;
        int g = 0;
        while (!bus.frame_tick && g < 40) begin
            step();
            g++;
        end
        if (!bus.frame_tick) timeout("wait_tick");
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            wait_tick();
            step();
        end
    endtask

    task automatic wait_en;
        int g = 0;
        while (!bus.phys_en && g < 40) begin
            step();
            g++;
        end
        if (!bus.phys_en) timeout("wait_en");
    endtask

    task automatic strobe;
        wait_en();
        step();
        bus.phys_valid = 1'b1;
        step();
        bus.phys_valid = 1'b0;
    endtask

    task automatic score_point(input logic [1:0] w);
        bus.phys_game_over = 1'b0;
        strobe();
        bus.phys_game_over = 1'b1;
        bus.phys_winner    = w;
        strobe();
    endtask

    task automatic pulse_start;
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
    endtask

    task automatic pulse_pause;
        bus.pause_btn = 1'b1;
        step();
        bus.pause_btn = 1'b0;
    endtask

    task automatic setv(input int i, input int act, input int arg, input logic [2:0] st,
                        input logic [3:0] p1, input logic [3:0] p2, input logic [1:0] win,
                        input logic rstn);
        vecs[i] = '{act, arg, st, p1, p2, win, rstn};
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            case (vecs[i].act)
                A_START: pulse_start();
                A_PAUSE: pulse_pause();
                A_TICKS: wait_ticks(vecs[i].arg);
                default: score_point(2'(vecs[i].arg));
            endcase
            chk($sformatf("v%0d.state", i), 8'(bus.state),        8'(vecs[i].st));
            chk($sformatf("v%0d.p1", i),    8'(bus.p1_score),     8'(vecs[i].p1));
            chk($sformatf("v%0d.p2", i),    8'(bus.p2_score),     8'(vecs[i].p2));
            chk($sformatf("v%0d.win", i),   8'(bus.match_winner), 8'(vecs[i].win));
            chk($sformatf("v%0d.rstn", i),  8'(bus.phys_rst_n),   8'(vecs[i].rstn));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        setv(0,  A_START, 0, 3'd1, 4'd0, 4'd0, 2'd0, 1'b1);
        setv(1,  A_TICKS, 2, 3'd1, 4'd0, 4'd0, 2'd0, 1'b1);
        setv(2,  A_POINT, 2, 3'd4, 4'd0, 4'd1, 2'd0, 1'b1);
        setv(3,  A_TICKS, 1, 3'd4, 4'd0, 4'd1, 2'd0, 1'b1);
        setv(4,  A_TICKS, 1, 3'd1, 4'd0, 4'd1, 2'd0, 1'b1);
        setv(5,  A_TICKS, 3, 3'd2, 4'd0, 4'd1, 2'd0, 1'b1);
        setv(6,  A_PAUSE, 0, 3'd3, 4'd0, 4'd1, 2'd0, 1'b1);
        setv(7,  A_TICKS, 2, 3'd3, 4'd0, 4'd1, 2'd0, 1'b1);
        setv(8,  A_PAUSE, 0, 3'd2, 4'd0, 4'd1, 2'd0, 1'b1);
        setv(9,  A_POINT, 1, 3'd4, 4'd1, 4'd1, 2'd0, 1'b1);
        setv(10, A_TICKS, 2, 3'd1, 4'd1, 4'd1, 2'd0, 1'b1);
        setv(11, A_TICKS, 3, 3'd2, 4'd1, 4'd1, 2'd0, 1'b1);
        setv(12, A_POINT, 2, 3'd5, 4'd1, 4'd2, 2'd2, 1'b1);
        setv(13, A_PAUSE, 0, 3'd5, 4'd1, 4'd2, 2'd2, 1'b1);
        setv(14, A_TICKS, 1, 3'd5, 4'd1, 4'd2, 2'd2, 1'b1);
        setv(15, A_START, 0, 3'd0, 4'd1, 4'd2, 2'd2, 1'b0);
        setv(16, A_TICKS, 1, 3'd0, 4'd1, 4'd2, 2'd2, 1'b0);
        setv(17, A_START, 0, 3'd1, 4'd0, 4'd0, 2'd0, 1'b1);
        setv(18, A_PAUSE, 0, 3'd1, 4'd0, 4'd0, 2'd0, 1'b1);
        setv(19, A_TICKS, 3, 3'd2, 4'd0, 4'd0, 2'd0, 1'b1);

        bus.start_btn      = 1'b0;
        bus.pause_btn      = 1'b0;
        bus.p1_btn_in      = 4'hF;
        bus.p2_btn_in      = 4'hA;
        bus.phys_game_over = 1'b0;
        bus.phys_winner    = 2'd0;
        bus.phys_valid     = 1'b0;

        // Reset values and divider period
        rst = 1'b1;
        repeat (3) step();
        chk("rst.state", 8'(bus.state), 8'd0);
        chk("rst.rstn",  8'(bus.phys_rst_n), 8'd0);
        chk("rst.tick",  8'(bus.frame_tick), 8'd0);
        chk("rst.en",    8'(bus.phys_en), 8'd0);
        chk("rst.p1",    8'(bus.p1_score), 8'd0);
        chk("rst.p2",    8'(bus.p2_score), 8'd0);
        chk("rst.btn",   8'(bus.p1_btn_out), 8'd0);
        rst = 1'b0;
        wait_tick();
        chk("idle.en_at_tick", 8'(bus.phys_en), 8'd0);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!bus.frame_tick && cnt < 40);
        chk("tick.period", 8'(cnt), 8'd10);

        // Start, then look inside SERVE at the third tick
        run_vecs(0, 1);
        wait_tick();
        chk("serve.en_at_tick", 8'(bus.phys_en), 8'd0);
        chk("serve.p1_btn",     8'(bus.p1_btn_out), 8'd0);
        chk("serve.state",      8'(bus.state), 8'd1);
        step();
        chk("play.state", 8'(bus.state), 8'd2);
        wait_en();
        chk("play.p1_btn", 8'(bus.p1_btn_out), 8'hF);
        chk("play.p2_btn", 8'(bus.p2_btn_out), 8'hA);
        step();
        chk("play.en_off_tick", 8'(bus.phys_en), 8'd0);

        run_vecs(2, 19);

        // game_over still held from the match-ending point: not re-armed, so no score
        strobe();
        chk("unarmed.state", 8'(bus.state), 8'd2);
        chk("unarmed.p2",    8'(bus.p2_score), 8'd0);
        score_point(2'd2);
        chk("p2pt.state", 8'(bus.state), 8'd4);
        chk("p2pt.p2",    8'(bus.p2_score), 8'd1);
        wait_ticks(5);
        chk("reserve.state", 8'(bus.state), 8'd2);
        strobe();
        strobe();
        chk("held.state", 8'(bus.state), 8'd2);
        chk("held.p2",    8'(bus.p2_score), 8'd1);

        // Pause freezes the engine across several ticks
        pulse_pause();
        chk("pause.state", 8'(bus.state), 8'd3);
        for (int k = 0; k < 5; k++) begin
            wait_tick();
            chk($sformatf("pause.en%0d", k), 8'(bus.phys_en), 8'd0);
            chk($sformatf("pause.btn%0d", k), 8'(bus.p1_btn_out), 8'd0);
            step();
        end
        chk("pause.hold", 8'(bus.state), 8'd3);
        pulse_pause();
        chk("resume.state", 8'(bus.state), 8'd2);

        // Point and pause in the same cycle: point wins
        bus.phys_game_over = 1'b0;
        strobe();
        bus.phys_game_over = 1'b1;
        bus.phys_winner    = 2'd1;
        wait_en();
        step();
        bus.phys_valid = 1'b1;
        bus.pause_btn  = 1'b1;
        step();
        bus.phys_valid = 1'b0;
        bus.pause_btn  = 1'b0;
        chk("race.state", 8'(bus.state), 8'd4);
        chk("race.p1",    8'(bus.p1_score), 8'd1);
        chk("race.p2",    8'(bus.p2_score), 8'd1);

        // Reset mid-match in POINT
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst.state", 8'(bus.state), 8'd0);
        chk("mrst.p1",    8'(bus.p1_score), 8'd0);
        chk("mrst.p2",    8'(bus.p2_score), 8'd0);
        chk("mrst.win",   8'(bus.match_winner), 8'd0);
        chk("mrst.rstn",  8'(bus.phys_rst_n), 8'd0);
        chk("mrst.tick",  8'(bus.frame_tick), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
